gcd_controller: RTL

//  Control FSM for the Euclid GCD datapath. Sequences LOAD, MAX/MIN ordering, the modulo loop and the termination check
//  by driving the datapath's ALU mode, operand-select and write-back strobes. Consumes the datapath's termination flag.

---
 rtl/gcd_pkg.sv | 31 +++
 rtl/gcd_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_pkg : state codes and ALU mode codes shared by the GCD blocks    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gcd_pkg;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_LOAD  = 4'd1;
  localparam state_t ST_MAX   = 4'd2;
  localparam state_t ST_MIN   = 4'd3;
  localparam state_t ST_XFER  = 4'd4;
  localparam state_t ST_MOD   = 4'd5;
  localparam state_t ST_CHECK = 4'd6;
  localparam state_t ST_NEXT  = 4'd7;
  localparam state_t ST_DONE  = 4'd8;

  localparam logic [2:0] GCD_MAX = 3'd0;
  localparam logic [2:0] GCD_MIN = 3'd1;
  localparam logic [2:0] GCD_MOD = 3'd2;
  localparam logic [2:0] GCD_NOP = 3'd7;

  function automatic logic is_alu_phase(input state_t s);
    return (s == ST_MAX) || (s == ST_MIN) || (s == ST_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_controller : Moore control FSM sequencing the Euclid datapath    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned MAX_ITER = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       valid_i,
  output logic [2:0] alu_mode_o,
  output logic       zahl1_to_alu_a_o,
  output logic       zahl2_to_alu_b_o,
  output logic       wren_zw_gross_o,
  output logic       wren_zw_klein_o,
  output logic       wren_zw_in_zahlen_o,
  output logic       wren_erg_modulo_o,
  output logic       wren_to_new_numbers_o,
  output logic       check_for_termination_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int unsigned LAT_W  = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int unsigned ITER_W = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1;
  localparam logic [LAT_W-1:0]  C_LAT_LAST = LAT_W'(ALU_LAT);
  localparam logic [ITER_W-1:0] C_ITER_MAX = ITER_W'(MAX_ITER);

  state_t            r_state, w_state_next;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_next;
  logic [ITER_W-1:0] r_iter_cnt, w_iter_next;
  logic              w_timeout;

  logic [2:0] r_alu_mode, w_alu_mode;
  logic       r_sel, w_sel;
  logic       r_wr_gross, w_wr_gross;
  logic       r_wr_klein, w_wr_klein;
  logic       r_wr_in_zahlen, w_wr_in_zahlen;
  logic       r_wr_erg, w_wr_erg;
  logic       r_wr_new, w_wr_new;
  logic       r_check, w_check;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_error, w_error;
  logic       w_lat_next_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_lat_cnt      <= '0;
      r_iter_cnt     <= '0;
      r_alu_mode     <= '0;
      r_sel          <= 1'b0;
      r_wr_gross     <= 1'b0;
      r_wr_klein     <= 1'b0;
      r_wr_in_zahlen <= 1'b0;
      r_wr_erg       <= 1'b0;
      r_wr_new       <= 1'b0;
      r_check        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_lat_cnt      <= w_lat_next;
      r_iter_cnt     <= w_iter_next;
      r_alu_mode     <= w_alu_mode;
      r_sel          <= w_sel;
      r_wr_gross     <= w_wr_gross;
      r_wr_klein     <= w_wr_klein;
      r_wr_in_zahlen <= w_wr_in_zahlen;
      r_wr_erg       <= w_wr_erg;
      r_wr_new       <= w_wr_new;
      r_check        <= w_check;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_error        <= w_error;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_MAX;
      ST_MAX:   if (r_lat_cnt == C_LAT_LAST) w_state_next = ST_MIN;
      ST_MIN:   if (r_lat_cnt == C_LAT_LAST) w_state_next = ST_XFER;
      ST_XFER:  w_state_next = ST_MOD;
      ST_MOD:   if (r_lat_cnt == C_LAT_LAST) w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (valid_i) begin
          w_state_next = ST_DONE;
        end else if (r_iter_cnt == C_ITER_MAX) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end else begin
          w_state_next = ST_NEXT;
        end
      end
      ST_NEXT:  w_state_next = ST_MOD;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase

    if (abort_i && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
      w_timeout    = 1'b0;
    end

    // Latency counter restarts whenever an ALU phase is (re)entered.
    if (is_alu_phase(w_state_next) && (w_state_next == r_state)) begin
      w_lat_next = r_lat_cnt + 1'b1;
    end else begin
      w_lat_next = '0;
    end

    w_iter_next = r_iter_cnt;
    if (w_state_next == ST_LOAD) begin
      w_iter_next = '0;
    end else if ((r_state == ST_NEXT) && (r_iter_cnt != C_ITER_MAX)) begin
      w_iter_next = r_iter_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    w_alu_mode      = '0;
    w_sel           = 1'b0;
    w_wr_gross      = 1'b0;
    w_wr_klein      = 1'b0;
    w_wr_in_zahlen  = 1'b0;
    w_wr_erg        = 1'b0;
    w_wr_new        = 1'b0;
    w_check         = 1'b0;
    w_done          = 1'b0;
    w_error         = 1'b0;
    w_busy          = (w_state_next != ST_IDLE);
    w_lat_next_last = (w_lat_next == C_LAT_LAST);
    case (w_state_next)
      ST_MAX: begin
        w_alu_mode = GCD_MAX;
        w_sel      = 1'b1;
        w_wr_gross = w_lat_next_last;
      end
      ST_MIN: begin
        w_alu_mode = GCD_MIN;
        w_sel      = 1'b1;
        w_wr_klein = w_lat_next_last;
      end
      ST_MOD: begin
        w_alu_mode = GCD_MOD;
        w_sel      = 1'b1;
        w_wr_erg   = w_lat_next_last;
      end
      ST_XFER:  w_wr_in_zahlen = 1'b1;
      ST_CHECK: w_check        = 1'b1;
      ST_NEXT:  w_wr_new       = 1'b1;
      ST_DONE: begin
        w_done  = 1'b1;
        w_error = w_timeout;
      end
      default: ;
    endcase
  end

  assign alu_mode_o              = r_alu_mode;
  assign zahl1_to_alu_a_o        = r_sel;
  assign zahl2_to_alu_b_o        = r_sel;
  assign wren_zw_gross_o         = r_wr_gross;
  assign wren_zw_klein_o         = r_wr_klein;
  assign wren_zw_in_zahlen_o     = r_wr_in_zahlen;
  assign wren_erg_modulo_o       = r_wr_erg;
  assign wren_to_new_numbers_o   = r_wr_new;
  assign check_for_termination_o = r_check;
  assign busy_o                  = r_busy;
  assign done_o                  = r_done;
  assign error_o                 = r_error;

endmodule
`default_nettype wire
